// File: rtl/gamepad_pkg.sv
// Shared constants and FSM state types for the gamepad-to-switch bridge.
//   PAD_*  : bit positions inside the USB report byte {R,L,D,U,START,SELECT,B,A}
//   SW_*   : bit positions inside the game switch vector {C2,S2,C1,S1,J1,R1,L1,D1,U1}
//   coin_st_e / rst_st_e : coin-pulse and game-reset sequencer states
package gamepad_pkg;

  localparam int PAD_A      = 0;
  localparam int PAD_B      = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START  = 3;
  localparam int PAD_U      = 4;
  localparam int PAD_D      = 5;
  localparam int PAD_L      = 6;
  localparam int PAD_R      = 7;

  localparam int SW_U  = 0;
  localparam int SW_D  = 1;
  localparam int SW_L  = 2;
  localparam int SW_R  = 3;
  localparam int SW_J1 = 4;
  localparam int SW_S1 = 5;
  localparam int SW_C1 = 6;
  localparam int SW_S2 = 7;
  localparam int SW_C2 = 8;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_st_e;

  typedef enum logic [1:0] {
    RST_HOLD    = 2'd0,
    RST_WAIT_VS = 2'd1,
    RST_RUN     = 2'd2
  } rst_st_e;

endpackage

// File: rtl/gamepad_sw_ctrl_ms_tick_counter.sv
// ms_tick_counter: millisecond-tick interval counter.
//   clk_i/rst_ni : clock, async active-low reset (count returns to 0)
//   tick_i       : 1 ms strobe; each strobe advances the count by one
//   clr_i        : restart the interval (count <= 0), wins over tick_i
//   done_o       : LIMIT ticks have elapsed since the last clear; the count
//                  holds there until cleared again
module ms_tick_counter #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (tick_i && !done_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gamepad_sw_ctrl.sv
// gamepad_sw_ctrl: USB gamepad report -> galaxian I_SW switch vector and
// game-core reset sequencer, all in the clk24 domain.
//   clk24, BTN_nRESET : clock, async active-low reset
//   pad_data/pad_ena  : report byte and its one-cycle valid strobe
//   vsync_in          : asynchronous VSYNC; game reset releases on its rising edge
//   sw_out            : registered {C2,S2,C1,S1,J1,R1,L1,D1,U1}, 0 while game in reset
//   game_rst_n        : active-low reset to the game core
//   pad_alive         : a report arrived within the last TIMEOUT_MS
//   led               : low nibble of the latched report
// Build option: define AUTOFIRE_EN to make a held A button fire a square wave
// with AUTOFIRE_MS half-period; otherwise J1 follows A directly.
module gamepad_sw_ctrl
  import gamepad_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 24000,
  parameter int unsigned TIMEOUT_MS  = 100,
  parameter int unsigned COIN_MS     = 80,
  parameter int unsigned COIN_GAP_MS = 200,
  parameter int unsigned HOLD_MS     = 2000,
  parameter int unsigned RST_MS      = 50,
  parameter int unsigned AUTOFIRE_MS = 33
) (
  input  logic       clk24,
  input  logic       BTN_nRESET,
  input  logic [7:0] pad_data,
  input  logic       pad_ena,
  input  logic       vsync_in,
  output logic [8:0] sw_out,
  output logic       game_rst_n,
  output logic       pad_alive,
  output logic [3:0] led
);

  if (TICK_DIV < 1 || TIMEOUT_MS < 1 || COIN_MS < 1 || COIN_GAP_MS < 1 ||
      HOLD_MS < 1 || RST_MS < 1 || AUTOFIRE_MS < 1) begin : g_param_err
    $error("gamepad_sw_ctrl: all timing parameters must be >= 1");
  end

  localparam int unsigned PW = $clog2(TICK_DIV + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    rpt_q, rpt_d;
  logic          alive_q, alive_d;
  logic          b_prev_q;
  logic          armed_q, armed_d;
  coin_st_e      coin_q, coin_d;
  rst_st_e       rst_st_q, rst_st_d;
  logic [2:0]    vs_q;
  logic [8:0]    sw_q, sw_d;
  logic          game_rst_n_q;

  logic tick, tmo_done, coin_done, gap_done, hold_done, rcnt_done;
  logic run, b_rise, combo, req, vs_rise, j1;

  // ---- 1 ms prescaler ----
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // ---- report latch with dead-pad timeout; a fresh report beats expiry ----
  ms_tick_counter #(.LIMIT(TIMEOUT_MS)) u_tmo (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick), .clr_i(pad_ena), .done_o(tmo_done)
  );

  always_comb begin
    rpt_d   = rpt_q;
    alive_d = alive_q;
    if (pad_ena) begin
      rpt_d   = pad_data;
      alive_d = 1'b1;
    end else if (tmo_done) begin
      rpt_d   = '0;
      alive_d = 1'b0;
    end
  end

  assign run    = (rst_st_q == RST_RUN);
  assign b_rise = rpt_q[PAD_B] & ~b_prev_q;

  // ---- coin pulse shaper: each phase ends on the first tick after its
  //      counter is satisfied, so the first (partial) tick never shortens it ----
  ms_tick_counter #(.LIMIT(COIN_MS)) u_coin (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick),
    .clr_i(coin_q != COIN_PULSE), .done_o(coin_done)
  );
  ms_tick_counter #(.LIMIT(COIN_GAP_MS)) u_gap (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick),
    .clr_i(coin_q != COIN_GAP), .done_o(gap_done)
  );

  always_comb begin
    coin_d = coin_q;
    unique case (coin_q)
      COIN_IDLE:  if (b_rise)             coin_d = COIN_PULSE;
      COIN_PULSE: if (tick && coin_done)  coin_d = COIN_GAP;
      COIN_GAP:   if (tick && gap_done)   coin_d = COIN_IDLE;
      default:                            coin_d = COIN_IDLE;
    endcase
    if (!run) coin_d = COIN_IDLE;
  end

  // ---- START+SELECT hold combo; re-arms only once both are released ----
  assign combo = rpt_q[PAD_START] & rpt_q[PAD_SELECT];

  ms_tick_counter #(.LIMIT(HOLD_MS)) u_hold (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick), .clr_i(!combo), .done_o(hold_done)
  );

  assign req = combo & hold_done & armed_q;

  always_comb begin
    armed_d = armed_q;
    if (req)                                          armed_d = 1'b0;
    else if (!rpt_q[PAD_START] && !rpt_q[PAD_SELECT]) armed_d = 1'b1;
  end

  // ---- VSYNC: two sync flops, third flop for edge detect ----
  assign vs_rise = vs_q[1] & ~vs_q[2];

  // ---- game reset sequencer; counter sits at 0 outside HOLD so every
  //      entry into HOLD starts a full RST_MS interval ----
  ms_tick_counter #(.LIMIT(RST_MS)) u_rst (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick),
    .clr_i(rst_st_q != RST_HOLD), .done_o(rcnt_done)
  );

  always_comb begin
    rst_st_d = rst_st_q;
    unique case (rst_st_q)
      RST_HOLD:    if (rcnt_done) rst_st_d = RST_WAIT_VS;
      RST_WAIT_VS: if (vs_rise)   rst_st_d = RST_RUN;
      RST_RUN:     if (req)       rst_st_d = RST_HOLD;
      default:                    rst_st_d = RST_HOLD;
    endcase
  end

  // ---- fire button ----
`ifdef AUTOFIRE_EN
  logic af_ph_q, af_ph_d, af_done;

  ms_tick_counter #(.LIMIT(AUTOFIRE_MS)) u_af (
    .clk_i(clk24), .rst_ni(BTN_nRESET), .tick_i(tick),
    .clr_i(!rpt_q[PAD_A] || af_done), .done_o(af_done)
  );

  // Phase parks high while A is up so the next press fires immediately.
  always_comb begin
    af_ph_d = af_ph_q;
    if (!rpt_q[PAD_A]) af_ph_d = 1'b1;
    else if (af_done)  af_ph_d = ~af_ph_q;
  end

  always_ff @(posedge clk24 or negedge BTN_nRESET) begin
    if (!BTN_nRESET) af_ph_q <= 1'b1;
    else             af_ph_q <= af_ph_d;
  end

  assign j1 = rpt_q[PAD_A] & af_ph_q;
`else
  assign j1 = rpt_q[PAD_A];
`endif

  // ---- switch vector; opposing directions cancel to neutral ----
  always_comb begin
    sw_d = '0;
    if (run) begin
      sw_d[SW_U]  = rpt_q[PAD_U] & ~rpt_q[PAD_D];
      sw_d[SW_D]  = rpt_q[PAD_D] & ~rpt_q[PAD_U];
      sw_d[SW_L]  = rpt_q[PAD_L] & ~rpt_q[PAD_R];
      sw_d[SW_R]  = rpt_q[PAD_R] & ~rpt_q[PAD_L];
      sw_d[SW_J1] = j1;
      sw_d[SW_S1] = rpt_q[PAD_START];
      sw_d[SW_C1] = (coin_q == COIN_PULSE);
      sw_d[SW_S2] = 1'b0;
      sw_d[SW_C2] = 1'b0;
    end
  end

  always_ff @(posedge clk24 or negedge BTN_nRESET) begin
    if (!BTN_nRESET) begin
      presc_q      <= '0;
      rpt_q        <= '0;
      alive_q      <= 1'b0;
      b_prev_q     <= 1'b0;
      armed_q      <= 1'b0;
      coin_q       <= COIN_IDLE;
      rst_st_q     <= RST_HOLD;
      vs_q         <= '0;
      sw_q         <= '0;
      game_rst_n_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      rpt_q        <= rpt_d;
      alive_q      <= alive_d;
      b_prev_q     <= rpt_q[PAD_B];
      armed_q      <= armed_d;
      coin_q       <= coin_d;
      rst_st_q     <= rst_st_d;
      vs_q         <= {vs_q[1:0], vsync_in};
      sw_q         <= sw_d;
      game_rst_n_q <= (rst_st_d == RST_RUN);
    end
  end

  assign sw_out     = sw_q;
  assign game_rst_n = game_rst_n_q;
  assign pad_alive  = alive_q;
  assign led        = rpt_q[3:0];

endmodule

// File: tb/tb_gamepad_sw_ctrl.sv
`timescale 1ns/1ps
module tb_gamepad_sw_ctrl;
  import gamepad_pkg::*;

  localparam int unsigned TICK_DIV = 4, TIMEOUT_MS = 10, COIN_MS = 3, COIN_GAP_MS = 5;
  localparam int unsigned HOLD_MS = 8, RST_MS = 2, AUTOFIRE_MS = 2;
`ifdef AUTOFIRE_EN
  localparam logic [8:0] M = 9'h1EF;   // J1 is a square wave under autofire
`else
  localparam logic [8:0] M = 9'h1FF;
`endif

  logic       clk24 = 1'b0, BTN_nRESET = 1'b0, pad_ena = 1'b0, vsync_in = 1'b0;
  logic [7:0] pad_data = 8'h00;
  logic [8:0] sw_out;
  logic       game_rst_n, pad_alive;
  logic [3:0] led;

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  bit keep = 1'b0;
  int c1_hi = 0, c1_rise = 0, rst_fall = 0;
  logic c1_prev = 1'b0, rstn_prev = 1'b0;

  always #5 clk24 = ~clk24;

  gamepad_sw_ctrl #(
    .TICK_DIV(TICK_DIV), .TIMEOUT_MS(TIMEOUT_MS), .COIN_MS(COIN_MS), .COIN_GAP_MS(COIN_GAP_MS),
    .HOLD_MS(HOLD_MS), .RST_MS(RST_MS), .AUTOFIRE_MS(AUTOFIRE_MS)
  ) dut (
    .clk24(clk24), .BTN_nRESET(BTN_nRESET), .pad_data(pad_data), .pad_ena(pad_ena),
    .vsync_in(vsync_in), .sw_out(sw_out), .game_rst_n(game_rst_n),
    .pad_alive(pad_alive), .led(led)
  );

  // Event counters sampled on the falling edge.
  always @(negedge clk24) begin
    c1_prev   <= sw_out[SW_C1];
    rstn_prev <= game_rst_n;
    if (sw_out[SW_C1])                c1_hi    <= c1_hi + 1;
    if (sw_out[SW_C1] && !c1_prev)    c1_rise  <= c1_rise + 1;
    if (!game_rst_n && rstn_prev)     rst_fall <= rst_fall + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: got %0h expected %0h", tag, got, exp); end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    n_chk++;
    assert (got >= lo && got <= hi) n_pass++;
    else begin n_fail++; $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi); end
  endtask

  // Advance n clocks; with keep set, re-send the current report every 8 cycles.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk24); #1;
      cyc++;
      pad_ena = keep && (cyc % 8 == 0);
    end
  endtask

  task automatic pad(input logic [7:0] d);
    pad_data = d; pad_ena = 1'b1; step();
  endtask

  initial begin
    int w, len, hi0, rise0, f0;

    // reset state
    step(3);
    chk("rst sw_out", sw_out, 0);
    chk("rst game_rst_n", game_rst_n, 0);
    chk("rst pad_alive", pad_alive, 0);
    chk("rst led", led, 0);

    // power-on: reset held until a vsync rise; switches forced off meanwhile
    keep = 1'b1; pad_data = 8'h11; BTN_nRESET = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("po held {rst_n,sw}", {game_rst_n, sw_out}, 0);
    end
    chk("po pad_alive", pad_alive, 1);
    chk("po led", led, 4'h1);
    vsync_in = 1'b1;
    step(2); chk("po rst_n +2", game_rst_n, 0);
    step();  chk("po rst_n +3", game_rst_n, 1);
    chk("po sw still 0", sw_out, 0);
    step();  chk("po sw U+A", sw_out & M, 9'h011 & M);
    vsync_in = 1'b0;

    // report latch and direction filter
    pad(8'h30); chk("led 30", led, 4'h0); chk("sw latency", sw_out & M, 9'h011 & M);
    step(); chk("socd U+D", sw_out, 9'h000);
    pad(8'hC0); step(); chk("socd L+R", sw_out, 9'h000);
    pad(8'h50); step(); chk("U+L", sw_out, 9'h005);
    pad(8'hA0); step(); chk("D+R", sw_out, 9'h00A);
    pad(8'h08); chk("led start", led, 4'h8); step(); chk("start S1", sw_out, 9'h020);
    pad(8'h04); chk("led select", led, 4'h4); step(); chk("select none", sw_out, 9'h000);

    // timeout
    keep = 1'b0; pad(8'h11); pad_ena = 1'b0;
    step(30); chk("tmo alive early", pad_alive, 1); chk("tmo led early", led, 4'h1);
    step(14); chk("tmo alive", pad_alive, 0); chk("tmo sw", sw_out, 0); chk("tmo led", led, 0);

    // coin: one pulse, re-press during gap ignored
    keep = 1'b1; hi0 = c1_hi; rise0 = c1_rise;
    pad(8'h02); step(6); pad(8'h00);
    w = 0;
    while (w < 40 && !(sw_out[SW_C1] == 1'b0 && c1_rise > rise0)) begin step(); w++; end
    chk("coin pulse ended", w < 40, 1);
    step(8); pad(8'h02); step(40);
    chk("coin one pulse", c1_rise - rise0, 1);
    chk_rng("coin pulse len", c1_hi - hi0, 12, 16);
    pad(8'h00); step(2); pad(8'h02); step(24);
    chk("coin new press", c1_rise - rise0, 2);
    pad(8'h00); step(30);

    // combo reset: one per press
    f0 = rst_fall;
    pad(8'h0C); step(40);
    chk("combo rst low", game_rst_n, 0);
    chk("combo fall", rst_fall - f0, 1);
    chk("combo sw forced", sw_out, 0);
    step(10); chk("combo wait vs", game_rst_n, 0);
    vsync_in = 1'b1; step(3); chk("combo rst release", game_rst_n, 1);
    vsync_in = 1'b0; step(); chk("combo sw S1", sw_out, 9'h020);
    step(50);
    chk("combo held no 2nd", game_rst_n, 1);
    chk("combo fall still 1", rst_fall - f0, 1);
    pad(8'h00); step(2); pad(8'h0C); step(40);
    chk("combo 2nd rst low", game_rst_n, 0);
    chk("combo fall 2", rst_fall - f0, 2);
    step(10); vsync_in = 1'b1; step(3); chk("combo 2nd release", game_rst_n, 1);
    vsync_in = 1'b0; pad(8'h00); step(2);

    // async reset mid-operation
    pad(8'h11); step(2); chk("mid sw pre", sw_out & M, 9'h011 & M);
    pad_ena = 1'b0;
    @(posedge clk24); #3; BTN_nRESET = 1'b0; #1;
    chk("mid async sw", sw_out, 0);
    chk("mid async rst_n", game_rst_n, 0);
    chk("mid async alive", pad_alive, 0);
    chk("mid async led", led, 0);
    #3; BTN_nRESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mid hold restart", {game_rst_n, sw_out}, 0);
    end
    vsync_in = 1'b1; step(3); chk("mid release", game_rst_n, 1);
    vsync_in = 1'b0; step(2);

`ifdef AUTOFIRE_EN
    pad(8'h01); step(); chk("af start high", sw_out[SW_J1], 1);
    w = 0;
    while (w < 20 && sw_out[SW_J1] == 1'b1) begin step(); w++; end
    chk("af first fall", w < 20, 1);
    len = 0;
    while (len < 20 && sw_out[SW_J1] == 1'b0) begin step(); len++; end
    chk("af low half", len, 8);
    len = 0;
    while (len < 20 && sw_out[SW_J1] == 1'b1) begin step(); len++; end
    chk("af high half", len, 8);
    pad(8'h00); step(); chk("af release", sw_out[SW_J1], 0);
`else
    len = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
